// File: rtl/branch_issue_sched_if.sv
// Branch issue scheduler bus.
// Groups the dispatch, writeback-wakeup, issue, flush and occupancy signals
// exchanged between rename/dispatch, the writeback network, the branch unit
// and the scheduler.
//   master : dispatch/writeback/branch-unit side (drives requests)
//   slave  : scheduler side (drives disp_ready/disp_slot/issue_*/count)
interface branch_issue_sched_if #(
  parameter int unsigned L  = 8,
  parameter int unsigned DW = 6,
  parameter int unsigned SW = 4
);
  localparam int unsigned IW = $clog2(L);

  // dispatch
  logic          disp_valid;
  logic          disp_ready;
  logic          disp_jump;
  logic [DW-1:0] disp_rt_addr;
  logic          disp_rt_ready;
  logic [SW-1:0] disp_rs_addr;
  logic          disp_rs_ready;
  logic [IW-1:0] disp_slot;
  // writeback wakeup broadcasts
  logic          wb_d_valid;
  logic [DW-1:0] wb_d_addr;
  logic          wb_s_valid;
  logic [SW-1:0] wb_s_addr;
  // issue to branch unit
  logic          issue_valid;
  logic          issue_ready;
  logic [IW-1:0] issue_slot;
  // control / status
  logic          flush;
  logic [IW:0]   count;

  modport master (
    output disp_valid, disp_jump, disp_rt_addr, disp_rt_ready,
           disp_rs_addr, disp_rs_ready,
           wb_d_valid, wb_d_addr, wb_s_valid, wb_s_addr,
           issue_ready, flush,
    input  disp_ready, disp_slot, issue_valid, issue_slot, count
  );

  modport slave (
    input  disp_valid, disp_jump, disp_rt_addr, disp_rt_ready,
           disp_rs_addr, disp_rs_ready,
           wb_d_valid, wb_d_addr, wb_s_valid, wb_s_addr,
           issue_ready, flush,
    output disp_ready, disp_slot, issue_valid, issue_slot, count
  );
endinterface

// File: rtl/branch_issue_sched.sv
// Branch buffer issue scheduler.
// Allocates branch buffer slots at dispatch, tracks rt/rs operand readiness
// through writeback wakeups, and offers the oldest ready entry's slot index
// to the branch unit over a valid/ready handshake. Flush squashes everything.
// Ports:
//   clk   : clock, rising edge
//   n_rst : asynchronous active-low reset
//   bus   : scheduler side of branch_issue_sched_if (dispatch, wakeup,
//           issue, flush, count)
module branch_issue_sched #(
  parameter int unsigned L  = 8,
  parameter int unsigned DW = 6,
  parameter int unsigned SW = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  branch_issue_sched_if.slave   bus
);
  localparam int unsigned IW = $clog2(L);
  localparam int unsigned CW = IW + 1;

  // entry state
  logic [L-1:0]  valid_q, valid_d;
  logic [L-1:0]  jump_q, jump_d;
  logic [L-1:0]  rt_rdy_q, rt_rdy_d;
  logic [L-1:0]  rs_rdy_q, rs_rdy_d;
  logic [DW-1:0] rt_tag_q [L];
  logic [DW-1:0] rt_tag_d [L];
  logic [SW-1:0] rs_tag_q [L];
  logic [SW-1:0] rs_tag_d [L];
  // older_q[i][j] = 1 when entry i was dispatched before entry j
  logic [L-1:0]  older_q [L];
  logic [L-1:0]  older_d [L];
  logic [CW-1:0] count_q, count_d;

  logic [L-1:0]  ready;
  logic [L-1:0]  oldest;
  logic [IW-1:0] iss_idx;
  logic          iss_any;
  logic [IW-1:0] free_idx;
  logic          disp_rdy;
  logic          iss_vld;
  logic          disp_fire;
  logic          iss_fire;

  assign ready = valid_q & rt_rdy_q & (jump_q | rs_rdy_q);

  // An entry is the oldest ready one when no other ready entry is older.
  always_comb begin
    oldest = ready;
    for (int unsigned i = 0; i < L; i++) begin
      for (int unsigned j = 0; j < L; j++) begin
        if (i != j && ready[j] && older_q[j][i]) oldest[i] = 1'b0;
      end
    end
  end

  always_comb begin
    iss_idx = '0;
    iss_any = 1'b0;
    for (int unsigned i = 0; i < L; i++) begin
      if (oldest[i] && !iss_any) begin
        iss_idx = IW'(i);
        iss_any = 1'b1;
      end
    end
  end

  // Lowest free slot; an issuing entry is still valid this cycle, so it is
  // never offered for allocation until the following cycle.
  always_comb begin
    free_idx = '0;
    for (int unsigned i = L; i > 0; i--) begin
      if (!valid_q[i-1]) free_idx = IW'(i - 1);
    end
  end

  assign disp_rdy  = (count_q < CW'(L)) && !bus.flush;
  assign iss_vld   = iss_any && !bus.flush;
  assign disp_fire = bus.disp_valid && disp_rdy;
  assign iss_fire  = iss_vld && bus.issue_ready;

  assign bus.disp_ready  = disp_rdy;
  assign bus.disp_slot   = free_idx;
  assign bus.issue_valid = iss_vld;
  assign bus.issue_slot  = iss_idx;
  assign bus.count       = count_q;

  always_comb begin
    valid_d  = valid_q;
    jump_d   = jump_q;
    rt_rdy_d = rt_rdy_q;
    rs_rdy_d = rs_rdy_q;
    rt_tag_d = rt_tag_q;
    rs_tag_d = rs_tag_q;
    older_d  = older_q;
    count_d  = count_q + CW'(disp_fire) - CW'(iss_fire);

    // wakeups
    for (int unsigned i = 0; i < L; i++) begin
      if (valid_q[i] && bus.wb_d_valid && rt_tag_q[i] == bus.wb_d_addr)
        rt_rdy_d[i] = 1'b1;
      if (valid_q[i] && bus.wb_s_valid && rs_tag_q[i] == bus.wb_s_addr)
        rs_rdy_d[i] = 1'b1;
    end

    if (iss_fire) valid_d[iss_idx] = 1'b0;

    if (disp_fire) begin
      valid_d[free_idx]  = 1'b1;
      jump_d[free_idx]   = bus.disp_jump;
      rt_tag_d[free_idx] = bus.disp_rt_addr;
      rs_tag_d[free_idx] = bus.disp_rs_addr;
      // same-cycle writeback bypass so a coincident wakeup is not lost
      rt_rdy_d[free_idx] = bus.disp_rt_ready ||
                           (bus.wb_d_valid && bus.wb_d_addr == bus.disp_rt_addr);
      rs_rdy_d[free_idx] = bus.disp_rs_ready ||
                           (bus.wb_s_valid && bus.wb_s_addr == bus.disp_rs_addr);
      // new entry is youngest: everyone else is older, it is older than none
      for (int unsigned j = 0; j < L; j++) begin
        if (IW'(j) != free_idx) older_d[j][free_idx] = 1'b1;
      end
      older_d[free_idx] = '0;
    end

    if (bus.flush) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_q  <= '0;
      jump_q   <= '0;
      rt_rdy_q <= '0;
      rs_rdy_q <= '0;
      rt_tag_q <= '{default: '0};
      rs_tag_q <= '{default: '0};
      older_q  <= '{default: '0};
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      jump_q   <= jump_d;
      rt_rdy_q <= rt_rdy_d;
      rs_rdy_q <= rs_rdy_d;
      rt_tag_q <= rt_tag_d;
      rs_tag_q <= rs_tag_d;
      older_q  <= older_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_branch_issue_sched.sv
// Scoreboard bench for branch_issue_sched (L=4, small tags to force matches).
module tb_branch_issue_sched;
  localparam int unsigned L  = 4;
  localparam int unsigned DW = 3;
  localparam int unsigned SW = 2;

  logic clk;
  logic n_rst;

  branch_issue_sched_if #(.L(L), .DW(DW), .SW(SW)) bus ();

  branch_issue_sched #(.L(L), .DW(DW), .SW(SW)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: one record per slot, age given by dispatch sequence
  typedef struct {
    bit v; bit j; int rt; bit rtr; int rs; bit rsr; int seq;
  } ent_t;
  typedef struct {
    bit dr; int ds; bit iv; int is; int cnt;
  } exp_t;

  ent_t m [L];
  exp_t q [$];
  int   seq_ctr;
  int   n_chk;
  int   n_fail;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < L; i++) m[i] = '{default: 0};
  endtask

  // monitor: compares DUT outputs with the expectation queued for this cycle
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("disp_ready",  int'(bus.disp_ready),  int'(e.dr));
      chk("disp_slot",   int'(bus.disp_slot),   e.ds);
      chk("issue_valid", int'(bus.issue_valid), int'(e.iv));
      chk("issue_slot",  int'(bus.issue_slot),  e.is);
      chk("count",       int'(bus.count),       e.cnt);
    end
  end

  // one clock of stimulus: drive inputs, queue expected outputs, advance model
  task automatic step(input bit dv, input bit j, input int rt, input bit rtr,
                      input int rs, input bit rsr, input bit wdv, input int wd,
                      input bit wsv, input int ws, input bit ir, input bit fl);
    exp_t e;
    int n;
    int best;
    @(negedge clk);
    bus.disp_valid    = dv;
    bus.disp_jump     = j;
    bus.disp_rt_addr  = DW'(rt);
    bus.disp_rt_ready = rtr;
    bus.disp_rs_addr  = SW'(rs);
    bus.disp_rs_ready = rsr;
    bus.wb_d_valid    = wdv;
    bus.wb_d_addr     = DW'(wd);
    bus.wb_s_valid    = wsv;
    bus.wb_s_addr     = SW'(ws);
    bus.issue_ready   = ir;
    bus.flush         = fl;

    n = 0;
    e.ds = -1;
    best = -1;
    for (int i = 0; i < L; i++) begin
      if (m[i].v) n++;
      else if (e.ds < 0) e.ds = i;
      if (m[i].v && m[i].rtr && (m[i].j || m[i].rsr))
        if (best < 0 || m[i].seq < m[best].seq) best = i;
    end
    if (e.ds < 0) e.ds = 0;
    e.cnt = n;
    e.dr  = (n < L) && !fl;
    e.iv  = (best >= 0) && !fl;
    e.is  = (best >= 0) ? best : 0;
    q.push_back(e);

    if (fl) begin
      model_clear();
    end else begin
      for (int i = 0; i < L; i++) begin
        if (m[i].v && wdv && m[i].rt == wd) m[i].rtr = 1;
        if (m[i].v && wsv && m[i].rs == ws) m[i].rsr = 1;
      end
      if (e.iv && ir) m[e.is].v = 0;
      if (dv && e.dr) begin
        m[e.ds].v   = 1;
        m[e.ds].j   = j;
        m[e.ds].rt  = rt;
        m[e.ds].rs  = rs;
        m[e.ds].rtr = rtr || (wdv && wd == rt);
        m[e.ds].rsr = rsr || (wsv && ws == rs);
        m[e.ds].seq = seq_ctr++;
      end
    end
  endtask

  task automatic idle(input bit ir);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ir, 0);
  endtask

  // asynchronous reset asserted away from any edge, with inputs left as-is
  task automatic rst_pulse();
    @(negedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    chk("reset count",       int'(bus.count),       0);
    chk("reset issue_valid", int'(bus.issue_valid), 0);
    chk("reset disp_slot",   int'(bus.disp_slot),   0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    model_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    seq_ctr = 0;
    model_clear();
    n_rst = 1'b0;
    bus.disp_valid = 0; bus.disp_jump = 0; bus.disp_rt_addr = '0;
    bus.disp_rt_ready = 0; bus.disp_rs_addr = '0; bus.disp_rs_ready = 0;
    bus.wb_d_valid = 0; bus.wb_d_addr = '0; bus.wb_s_valid = 0;
    bus.wb_s_addr = '0; bus.issue_ready = 0; bus.flush = 0;
    rst_pulse();

    // three fully-ready dispatches, held, then drained
    for (int i = 0; i < 3; i++) step(1, 0, i, 1, i, 1, 0, 0, 0, 0, 0, 0);
    idle(0);
    for (int i = 0; i < 4; i++) idle(1);

    // fill with rt pending, wake slot 2, then reallocate it
    for (int i = 0; i < 4; i++) step(1, 0, i + 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 7, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    idle(1);
    step(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) idle(1);

    // jump ignores rs; non-jump waits for rs wakeup
    step(1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    idle(1);

    // dispatch coincident with its own rt writeback
    step(1, 0, 6, 0, 0, 1, 1, 6, 0, 0, 0, 0);
    idle(1);
    idle(1);

    // age ordering: slot 3 older than re-used slot 1, both wake together
    rst_pulse();
    for (int i = 0; i < 4; i++) step(1, 0, i + 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 1, 0);
    idle(1);
    step(1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 4, 1, 2, 0, 0);
    idle(1);
    idle(1);
    idle(1);

    // flush with a full buffer and issue_ready high
    rst_pulse();
    for (int i = 0; i < 4; i++) step(1, 0, i, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1);
    idle(1);

    // randomized traffic with occasional flushes and mid-burst resets
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) == 0) rst_pulse();
      step($urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
           int'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) < 4, int'($urandom_range(0, 7)),
           $urandom_range(0, 9) < 4, int'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0);
    end
    idle(0);

    @(negedge clk);
    #3;
    chk("scoreboard drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
